game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/frame_delay_counter.sv | 39 +++
 rtl/game_sequencer.sv | 118 +++++++++++
 tb/tb_game_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the brick-breaker game-flow controller.
package game_pkg;

    // Encoding follows listed order; the display overlays decode game_state directly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_BALL_LOST = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_GAME_WON  = 3'd6
    } game_state_t;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_NUM_LEVELS   = 4;
    localparam int DEF_PAUSE_FRAMES = 120;

endpackage

// File: rtl/frame_delay_counter.sv
// Counts startOfFrame pulses while not cleared; done pulses on the pulse that reaches COUNT.
module frame_delay_counter
    import game_pkg::*;
#(
    parameter int COUNT = DEF_PAUSE_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic startOfFrame,
    output logic done
);

    localparam logic [7:0] LAST = 8'(COUNT - 1);

    logic [7:0] count_q, count_d;

    // done is combinational so the FSM leaves the pause on the same edge that sees the final frame.
    always_comb begin
        done    = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (startOfFrame) begin
            if (count_q == LAST) begin
                done    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences game phases, tracks lives and level, drives win/lose/restart.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int NUM_LEVELS   = DEF_NUM_LEVELS,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       ball_missed,
    input  logic       bricks_cleared,
    output logic       restartGame,
    output logic       win,
    output logic       lose,
    output logic       freeze,
    output logic       serve,
    output logic [2:0] lives,
    output logic [1:0] level_idx,
    output logic [2:0] game_state
);

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);

    game_state_t state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [1:0]  level_q, level_d;
    logic        restart_q, restart_d;
    logic        win_q, win_d;
    logic        lose_q, freeze_q, serve_q;
    logic        pause_clear, pause_done;

    // Counter is held clear outside the pauses, so a frame on the entry edge is never counted.
    assign pause_clear = !((state_q == ST_BALL_LOST) || (state_q == ST_LEVEL_UP));

    frame_delay_counter #(.COUNT(PAUSE_FRAMES)) u_pause (
        .clk          (clk),
        .reset        (reset),
        .clear        (pause_clear),
        .startOfFrame (startOfFrame),
        .done         (pause_done)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        restart_d = 1'b0;
        win_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER, ST_GAME_WON: begin
                if (startKey) begin
                    restart_d = 1'b1;
                    lives_d   = LIVES_INIT;
                    level_d   = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (startKey) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Level completion wins over a coincident miss.
                if (bricks_cleared) begin
                    if (level_q < LAST_LEVEL) begin
                        win_d   = 1'b1;
                        level_d = level_q + 2'd1;
                        state_d = ST_LEVEL_UP;
                    end else begin
                        state_d = ST_GAME_WON;
                    end
                end else if (ball_missed) begin
                    if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                    state_d = (lives_q <= 3'd1) ? ST_GAME_OVER : ST_BALL_LOST;
                end
            end
            ST_BALL_LOST, ST_LEVEL_UP: begin
                if (pause_done) state_d = ST_SERVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            level_q   <= '0;
            restart_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            freeze_q  <= 1'b1;
            serve_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            restart_q <= restart_d;
            win_q     <= win_d;
            lose_q    <= (state_d == ST_GAME_OVER);
            freeze_q  <= (state_d != ST_PLAY);
            serve_q   <= (state_d == ST_SERVE);
        end
    end

    assign restartGame = restart_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign freeze      = freeze_q;
    assign serve       = serve_q;
    assign lives       = lives_q;
    assign level_idx   = level_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboarded bench: driver pushes reference-model expectations, monitor compares after each edge.
module tb_game_sequencer;

    localparam int LV = 3;
    localparam int NL = 4;
    localparam int PF = 3;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_LOST = 3,
                   S_LEVELUP = 4, S_OVER = 5, S_WON = 6;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, startKey, ball_missed, bricks_cleared;
    logic       restartGame, win, lose, freeze, serve;
    logic [2:0] lives;
    logic [1:0] level_idx;
    logic [2:0] game_state;

    always #5 clk = ~clk;

    game_sequencer #(.LIVES(LV), .NUM_LEVELS(NL), .PAUSE_FRAMES(PF)) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .startKey       (startKey),
        .ball_missed    (ball_missed),
        .bricks_cleared (bricks_cleared),
        .restartGame    (restartGame),
        .win            (win),
        .lose           (lose),
        .freeze         (freeze),
        .serve          (serve),
        .lives          (lives),
        .level_idx      (level_idx),
        .game_state     (game_state)
    );

    typedef struct packed {
        logic       rg;
        logic       w;
        logic       lo;
        logic       fr;
        logic       sv;
        logic [2:0] lv;
        logic [1:0] lvl;
        logic [2:0] gs;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    int m_st    = S_IDLE;
    int m_lives = LV;
    int m_lvl   = 0;
    int m_rem   = 0;

    // Model: applies the game rules for one sampled edge and queues the expected outputs.
    task automatic step(input logic r, input logic sk, input logic bm, input logic bc, input logic sof);
        obs_t e;
        logic rg = 1'b0;
        logic w  = 1'b0;
        @(negedge clk);
        reset          = r;
        startKey       = sk;
        ball_missed    = bm;
        bricks_cleared = bc;
        startOfFrame   = sof;
        if (r) begin
            m_st = S_IDLE; m_lives = LV; m_lvl = 0; m_rem = 0;
        end else begin
            case (m_st)
                S_IDLE, S_OVER, S_WON:
                    if (sk) begin
                        rg = 1'b1; m_lives = LV; m_lvl = 0; m_st = S_SERVE;
                    end
                S_SERVE: if (sk) m_st = S_PLAY;
                S_PLAY: begin
                    if (bc) begin
                        if (m_lvl < NL - 1) begin
                            w = 1'b1; m_lvl = m_lvl + 1; m_st = S_LEVELUP; m_rem = PF;
                        end else begin
                            m_st = S_WON;
                        end
                    end else if (bm) begin
                        m_st    = (m_lives <= 1) ? S_OVER : S_LOST;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_rem   = PF;
                    end
                end
                S_LOST, S_LEVELUP:
                    if (sof) begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_st = S_SERVE;
                    end
                default: ;
            endcase
        end
        e.rg  = rg;
        e.w   = w;
        e.lo  = (m_st == S_OVER);
        e.fr  = (m_st != S_PLAY);
        e.sv  = (m_st == S_SERVE);
        e.lv  = 3'(m_lives);
        e.lvl = 2'(m_lvl);
        e.gs  = 3'(m_st);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic key();
        step(0, 1, 0, 0, 0);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{rg: restartGame, w: win, lo: lose, fr: freeze, sv: serve,
                        lv: lives, lvl: level_idx, gs: game_state};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got rg=%b w=%b lo=%b fr=%b sv=%b lives=%0d lvl=%0d st=%0d exp rg=%b w=%b lo=%b fr=%b sv=%b lives=%0d lvl=%0d st=%0d",
                             cycle, act.rg, act.w, act.lo, act.fr, act.sv, act.lv, act.lvl, act.gs,
                             e.rg, e.w, e.lo, e.fr, e.sv, e.lv, e.lvl, e.gs);
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b1; startKey = 1'b0; ball_missed = 1'b0;
        bricks_cleared = 1'b0; startOfFrame = 1'b0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);
        key(); idle(1); key(); idle(2);

        // Miss with a coincident frame on the entry edge; key/miss during the pause are ignored.
        step(0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 0);
        frames(PF);
        key(); idle(1);
        step(0, 0, 1, 0, 0);
        frames(PF);
        key(); idle(1);

        // Clear and miss together at one life: level completes, life kept.
        step(0, 0, 1, 1, 0);
        frames(PF);
        key();
        step(0, 0, 0, 1, 0);
        frames(1);
        step(1, 0, 0, 0, 0);
        idle(2);

        // Full run through every level to GAME_WON, then restart.
        key(); key();
        repeat (NL - 1) begin
            step(0, 0, 0, 1, 0);
            frames(PF);
            key();
        end
        step(0, 0, 0, 1, 0);
        idle(2);
        key(); key();

        // Lose all lives, then restart from GAME_OVER.
        repeat (LV - 1) begin
            step(0, 0, 1, 0, 0);
            frames(PF);
            key();
        end
        step(0, 0, 1, 0, 0);
        idle(3);
        key(); idle(2);

        repeat (3000) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
